// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two memory requesters, the arbiter and the shared
// instruction/data memory. The arbiter takes the slave view; the requester
// and memory side (CPU datapath, loader, RAM/IO mux) take the master view.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // Master 0: CPU datapath
  logic          m0_req;
  logic          m0_we;
  logic          m0_lock;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_gnt;
  logic          m0_rvalid;
  logic [DW-1:0] m0_rdata;

  // Master 1: debug / program loader
  logic          m1_req;
  logic          m1_we;
  logic          m1_lock;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_gnt;
  logic          m1_rvalid;
  logic [DW-1:0] m1_rdata;

  // Shared memory side
  logic [AW-1:0] mem_addr;
  logic          mem_read;
  logic          mem_write;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          busy;

  modport slave (
    input  m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_addr, mem_read, mem_write, mem_wdata,
    input  mem_rdata,
    output busy
  );

  modport master (
    output m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_addr, mem_read, mem_write, mem_wdata,
    output mem_rdata,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter in front of the single instruction/data memory.
// Round-robin between the CPU datapath (m0) and the loader (m1), with an
// optional ownership lock and one-cycle pipelined read-data return.
// A lock owner that stops requesting keeps the lock; the loader relies on
// this to hold the memory across gaps in its own traffic.
module mem_port_arbiter #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);

  // The return path assumes data appears exactly one cycle after the read.
  generate
    if (RD_LAT != 1) begin : g_badReadLatency
      $error("mem_port_arbiter supports only RD_LAT = 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    LOCK_NONE = 2'd0,
    LOCK_M0   = 2'd1,
    LOCK_M1   = 2'd2
  } lockState_e;

  lockState_e lock_q, lock_d;
  logic       lastGnt_q, lastGnt_d;
  logic       rdPend_q, rdPend_d;
  logic       rdOwner_q, rdOwner_d;

  logic gnt0;
  logic gnt1;
  logic anyGnt;
  logic gntWe;
  logic gntLock;

  // Pick at most one master: the lock owner exclusively, else round-robin.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    case (lock_q)
      LOCK_M0: gnt0 = bus.m0_req;
      LOCK_M1: gnt1 = bus.m1_req;
      default: begin
        if (bus.m0_req && bus.m1_req) begin
          gnt0 = lastGnt_q;
          gnt1 = ~lastGnt_q;
        end else begin
          gnt0 = bus.m0_req;
          gnt1 = bus.m1_req;
        end
      end
    endcase
    anyGnt  = gnt0 | gnt1;
    gntWe   = gnt1 ? bus.m1_we   : bus.m0_we;
    gntLock = gnt1 ? bus.m1_lock : bus.m0_lock;
  end

  // Route the granted master onto the memory; an idle bus is driven to zero.
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    if (gnt0) begin
      bus.mem_addr  = bus.m0_addr;
      bus.mem_wdata = bus.m0_wdata;
      bus.mem_read  = ~bus.m0_we;
      bus.mem_write = bus.m0_we;
    end else if (gnt1) begin
      bus.mem_addr  = bus.m1_addr;
      bus.mem_wdata = bus.m1_wdata;
      bus.mem_read  = ~bus.m1_we;
      bus.mem_write = bus.m1_we;
    end
  end

  // Next state: round-robin pointer, lock ownership and read-return tracking.
  always_comb begin
    lastGnt_d = lastGnt_q;
    lock_d    = lock_q;
    rdPend_d  = anyGnt & ~gntWe;
    rdOwner_d = rdOwner_q;
    if (anyGnt) begin
      lastGnt_d = gnt1;
      // While locked only the owner is ever granted, so a grant with lock=0
      // is either the owner releasing or an unlocked access.
      if (gntLock) begin
        lock_d = gnt1 ? LOCK_M1 : LOCK_M0;
      end else begin
        lock_d = LOCK_NONE;
      end
      if (!gntWe) begin
        rdOwner_d = gnt1;
      end
    end
  end

  // State registers; reset favours m0 in the first contention.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lastGnt_q <= 1'b1;
      lock_q    <= LOCK_NONE;
      rdPend_q  <= 1'b0;
      rdOwner_q <= 1'b0;
    end else begin
      lastGnt_q <= lastGnt_d;
      lock_q    <= lock_d;
      rdPend_q  <= rdPend_d;
      rdOwner_q <= rdOwner_d;
    end
  end

  // Grants, read-data steering to the issuing master, and the busy flag.
  always_comb begin
    bus.m0_gnt    = gnt0;
    bus.m1_gnt    = gnt1;
    bus.m0_rvalid = rdPend_q & ~rdOwner_q;
    bus.m1_rvalid = rdPend_q & rdOwner_q;
    bus.m0_rdata  = bus.m0_rvalid ? bus.mem_rdata : '0;
    bus.m1_rdata  = bus.m1_rvalid ? bus.mem_rdata : '0;
    bus.busy      = rdPend_q | (lock_q != LOCK_NONE);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a behavioural RAM plus input
// port register sits on the memory side, and a cycle-by-cycle vector table
// drives both masters; the asynchronous mid-cycle reset is hand-sequenced.
module tb_mem_port_arbiter;

  localparam logic [31:0] INPORT_ADDR = 32'h0000_FFF8;
  localparam logic [31:0] INPORT_VAL  = 32'h0000_5A5A;
  localparam int          NUM_VEC     = 28;

  typedef struct {
    logic        rst;
    logic        r0, w0, l0;
    logic [31:0] a0, d0;
    logic        r1, w1, l1;
    logic [31:0] a1, d1;
    logic [6:0]  flags;
    logic [31:0] eAddr, eWdata, eRdata0, eRdata1;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   compared = 0;
  int   mismatched = 0;

  logic [31:0] ram [256];
  vec_t        vecs [NUM_VEC];

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Memory model: synchronous write, registered one-cycle read, input port.
  always @(posedge clk) begin
    if (bus.mem_write && bus.mem_addr != INPORT_ADDR)
      ram[bus.mem_addr[9:2]] <= bus.mem_wdata;
    if (bus.mem_read)
      bus.mem_rdata <= (bus.mem_addr == INPORT_ADDR) ? INPORT_VAL : ram[bus.mem_addr[9:2]];
  end

  function automatic vec_t mk(input logic [31:0] r,
                              input logic [31:0] r0, input logic [31:0] w0, input logic [31:0] l0,
                              input logic [31:0] a0, input logic [31:0] d0,
                              input logic [31:0] r1, input logic [31:0] w1, input logic [31:0] l1,
                              input logic [31:0] a1, input logic [31:0] d1,
                              input logic [6:0] flags,
                              input logic [31:0] eAddr, input logic [31:0] eWdata,
                              input logic [31:0] eRdata0, input logic [31:0] eRdata1);
    vec_t v;
    v.rst = r[0];
    v.r0 = r0[0]; v.w0 = w0[0]; v.l0 = l0[0]; v.a0 = a0; v.d0 = d0;
    v.r1 = r1[0]; v.w1 = w1[0]; v.l1 = l1[0]; v.a1 = a1; v.d1 = d1;
    v.flags = flags;
    v.eAddr = eAddr; v.eWdata = eWdata; v.eRdata0 = eRdata0; v.eRdata1 = eRdata1;
    return v;
  endfunction

  task automatic checkOutput(input string what, input int idx,
                             input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL step %0d %s: got %h, expected %h", idx, what, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst          = v.rst;
    bus.m0_req   = v.r0; bus.m0_we = v.w0; bus.m0_lock = v.l0;
    bus.m0_addr  = v.a0; bus.m0_wdata = v.d0;
    bus.m1_req   = v.r1; bus.m1_we = v.w1; bus.m1_lock = v.l1;
    bus.m1_addr  = v.a1; bus.m1_wdata = v.d1;
  endtask

  // flags = {gnt0, gnt1, mem_read, mem_write, rvalid0, rvalid1, busy}
  task automatic checkVector(input int idx, input vec_t v);
    checkOutput("m0_gnt",    idx, 32'(bus.m0_gnt),    32'(v.flags[6]));
    checkOutput("m1_gnt",    idx, 32'(bus.m1_gnt),    32'(v.flags[5]));
    checkOutput("mem_read",  idx, 32'(bus.mem_read),  32'(v.flags[4]));
    checkOutput("mem_write", idx, 32'(bus.mem_write), 32'(v.flags[3]));
    checkOutput("m0_rvalid", idx, 32'(bus.m0_rvalid), 32'(v.flags[2]));
    checkOutput("m1_rvalid", idx, 32'(bus.m1_rvalid), 32'(v.flags[1]));
    checkOutput("busy",      idx, 32'(bus.busy),      32'(v.flags[0]));
    checkOutput("mem_addr",  idx, bus.mem_addr,  v.eAddr);
    checkOutput("mem_wdata", idx, bus.mem_wdata, v.eWdata);
    checkOutput("m0_rdata",  idx, bus.m0_rdata,  v.eRdata0);
    checkOutput("m1_rdata",  idx, bus.m1_rdata,  v.eRdata1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'hA000_0000 | i;
    bus.mem_rdata = '0;

    // Reset, then a single m0 read of word 4
    vecs[0]  = mk(0, 0,0,0,0,0,       0,0,0,0,0,              7'b0000000, 0,0,0,0);
    vecs[1]  = mk(1, 0,0,0,0,0,       0,0,0,0,0,              7'b0000000, 0,0,0,0);
    vecs[2]  = mk(1, 1,0,0,'h10,0,    0,0,0,'h44,'h55,        7'b1010000, 'h10,0,0,0);
    vecs[3]  = mk(1, 0,0,0,0,0,       0,0,0,0,0,              7'b0000101, 0,0,'hA000_0004,0);
    vecs[4]  = mk(1, 0,0,0,0,0,       0,0,0,0,0,              7'b0000000, 0,0,0,0);
    // Fresh reset, then continuous contention: m0, m1, m0, m1
    vecs[5]  = mk(0, 0,0,0,0,0,       0,0,0,0,0,              7'b0000000, 0,0,0,0);
    vecs[6]  = mk(1, 1,0,0,'h0,0,     1,0,0,'h4,0,            7'b1010000, 'h0,0,0,0);
    vecs[7]  = mk(1, 1,0,0,'h8,0,     1,0,0,'h4,0,            7'b0110101, 'h4,0,'hA000_0000,0);
    vecs[8]  = mk(1, 1,0,0,'h8,0,     1,0,0,'hC,0,            7'b1010011, 'h8,0,0,'hA000_0001);
    vecs[9]  = mk(1, 1,0,0,'h10,0,    1,0,0,'hC,0,            7'b0110101, 'hC,0,'hA000_0002,0);
    vecs[10] = mk(1, 0,0,0,0,0,       0,0,0,0,0,              7'b0000011, 0,0,0,'hA000_0003);
    vecs[11] = mk(1, 0,0,0,0,0,       0,0,0,0,0,              7'b0000000, 0,0,0,0);
    // m1 locked write, m1 idles while m0 starves, m1 unlocking read
    vecs[12] = mk(1, 0,0,0,0,0,       1,1,1,'h20,'hDEADBEEF,  7'b0101000, 'h20,'hDEADBEEF,0,0);
    vecs[13] = mk(1, 1,0,0,'h30,0,    0,0,0,0,0,              7'b0000001, 0,0,0,0);
    vecs[14] = mk(1, 1,0,0,'h30,0,    0,0,0,0,0,              7'b0000001, 0,0,0,0);
    vecs[15] = mk(1, 1,0,0,'h30,0,    0,0,0,0,0,              7'b0000001, 0,0,0,0);
    vecs[16] = mk(1, 1,0,0,'h30,0,    1,0,0,'h20,0,           7'b0110001, 'h20,0,0,0);
    vecs[17] = mk(1, 1,0,0,'h30,0,    0,0,0,0,0,              7'b1010011, 'h30,0,0,'hDEADBEEF);
    vecs[18] = mk(1, 0,0,0,0,0,       0,0,0,0,0,              7'b0000101, 0,0,'hA000_000C,0);
    vecs[19] = mk(1, 0,0,0,0,0,       0,0,0,0,0,              7'b0000000, 0,0,0,0);
    // m0 read followed immediately by an m1 write
    vecs[20] = mk(1, 1,0,0,'h8,0,     0,0,0,0,0,              7'b1010000, 'h8,0,0,0);
    vecs[21] = mk(1, 0,0,0,0,0,       1,1,0,'h4,'h12345678,   7'b0101101, 'h4,'h12345678,'hA000_0002,0);
    vecs[22] = mk(1, 0,0,0,0,0,       0,0,0,0,0,              7'b0000000, 0,0,0,0);
    vecs[23] = mk(1, 1,0,0,'h4,0,     0,0,0,0,0,              7'b1010000, 'h4,0,0,0);
    vecs[24] = mk(1, 0,0,0,0,0,       0,0,0,0,0,              7'b0000101, 0,0,'h12345678,0);
    // Memory-mapped input port read
    vecs[25] = mk(1, 0,0,0,0,0,       1,0,0,'hFFF8,0,         7'b0110000, 'hFFF8,0,0,0);
    vecs[26] = mk(1, 0,0,0,0,0,       0,0,0,0,0,              7'b0000011, 0,0,0,'h0000_5A5A);
    vecs[27] = mk(1, 0,0,0,0,0,       0,0,0,0,0,              7'b0000000, 0,0,0,0);

    applyStimulus(vecs[0]);
    for (int i = 0; i < NUM_VEC; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #2;
      checkVector(i, vecs[i]);
    end

    // Locked m0 read, then asynchronous reset between clock edges
    @(negedge clk);
    applyStimulus(mk(1, 1,0,1,'h8,0, 0,0,0,0,0, 7'b0, 0,0,0,0));
    #2;
    checkOutput("locked read gnt", 100, 32'(bus.m0_gnt), 32'd1);
    @(posedge clk);
    #1;
    applyStimulus(mk(1, 0,0,0,0,0, 0,0,0,0,0, 7'b0, 0,0,0,0));
    #1;
    checkOutput("pre-reset rvalid", 101, 32'(bus.m0_rvalid), 32'd1);
    checkOutput("pre-reset busy",   101, 32'(bus.busy),      32'd1);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("reset rvalid", 102, 32'(bus.m0_rvalid), 32'd0);
    checkOutput("reset rdata",  102, bus.m0_rdata,       32'd0);
    checkOutput("reset busy",   102, 32'(bus.busy),      32'd0);
    @(negedge clk);
    applyStimulus(mk(1, 1,0,0,'h0,0, 1,0,0,'h4,0, 7'b0, 0,0,0,0));
    #2;
    checkOutput("post-reset m0_gnt", 103, 32'(bus.m0_gnt), 32'd1);
    checkOutput("post-reset m1_gnt", 103, 32'(bus.m1_gnt), 32'd0);
    @(negedge clk);
    applyStimulus(mk(1, 0,0,0,0,0, 0,0,0,0,0, 7'b0, 0,0,0,0));
    #2;
    checkOutput("post-reset rvalid", 104, 32'(bus.m0_rvalid), 32'd1);
    checkOutput("post-reset rdata",  104, bus.m0_rdata,       32'hA000_0000);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single instruction/data memory (RAM, I/O-port registers and output mux) between two requesters: master 0 (CPU datapath) and master 1 (debug/program loader).
- Provides round-robin arbitration, optional ownership lock and pipelined read-return tracking.
- Drives the memory's addr, MemRead, MemWrite and WrData.
- Returns the memory's data output to the master that issued the read.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- RD_LAT, 1, memory read latency in cycles; fixed at 1 for this memory. Other values are unsupported.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets).
- m0_req  in  1  master 0 access request.
- m0_we  in  1  master 0 write (1) / read (0).
- m0_lock  in  1  master 0 keeps ownership after the current grant.
- m0_addr  in  AW  master 0 byte address.
- m0_wdata  in  DW  master 0 write data.
- m0_gnt  out  1  master 0 access accepted this cycle.
- m0_rvalid  out  1  master 0 read data valid.
- m0_rdata  out  DW  master 0 read data.
- m1_req, m1_we, m1_lock, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as master 0, for master 1.
- mem_addr  out  AW  to memory addr.
- mem_read  out  1  to memory MemRead.
- mem_write  out  1  to memory MemWrite.
- mem_wdata  out  DW  to memory WrData.
- mem_rdata  in  DW  from memory data.
- busy  out  1  a read is outstanding or a lock is held.

Behaviour:
- Reset values (rst=0, asynchronous):
  - last_gnt=1, so master 0 wins the first contention.
  - lock_owner=none; rd_pend=0; rd_owner=0.
  - m0_rvalid=m1_rvalid=0; busy=0.
  - With no requests: gnt=0, mem_read=mem_write=0, mem_addr=0, mem_wdata=0.
- Grant (combinational, same cycle as request):
  - Lock held: only the lock owner can be granted. The other master waits even if requesting.
  - No lock, one requester: that master is granted.
  - No lock, both requesting: grant the master != last_gnt.
  - At most one gnt per cycle.
  - A master holds req/we/addr/wdata stable until it sees gnt. Accepted at the rising edge where gnt=1.
- Memory drive:
  - In a grant cycle, mem_addr/mem_wdata come from the granted master.
  - mem_write = granted & we; mem_read = granted & ~we.
  - With no grant, controls are 0 and addr/wdata are 0.
- last_gnt updates to the granted master index on every grant edge.
- Lock:
  - If the granted master has lock=1 at the grant edge, lock_owner is set to that master.
  - Cleared at the first grant edge of the owner with lock=0.
  - An owner idle (req=0) keeps the lock; this starvation is acceptable and documented for the loader.
- Read return, fully pipelined:
  - A read granted in cycle N sets rd_pend=1 and rd_owner=master for cycle N+1.
  - In N+1 the owner's rvalid=1 and its rdata = mem_rdata (combinational passthrough). The other master's rdata = 0.
  - A new grant is allowed in cycle N+1, giving back-to-back reads at 1 per cycle.
- Write: completes at the grant edge; no rvalid.
  - A write in cycle N+1 after a read in N does not disturb that read's return.
- busy = rd_pend | (lock_owner != none).
- Reset mid-operation:
  - A pending rvalid is dropped and the lock is released.
  - Any memory write at that edge is not guaranteed.
  - Masters re-issue after reset.

Test Plan:
- Reset, then m0 read only, addr=0x10: m0_gnt=1 with mem_read=1, mem_addr=0x10 the same cycle. Next cycle m0_rvalid=1 and m0_rdata = RAM word 4.
- Both masters request every cycle, no lock: grants alternate m0,m1,m0,m1 (first m0 after reset), with one rvalid per cycle to the correct master.
- m1 write 0xDEADBEEF to 0x20 with lock=1, then m1 idle 3 cycles while m0 requests: m0_gnt=0 and busy=1. m1 then reads 0x20 with lock=0: rdata=0xDEADBEEF, lock released, m0 granted the next cycle.
- m0 read 0x8 in cycle N, m1 write 0x4 in N+1: m0_rvalid=1 in N+1 with old data, m1_rvalid stays 0, mem_write=1 in N+1.
- Assert rst=0 asynchronously mid-cycle after a read grant: m0_rvalid, busy and the lock clear immediately. After release, first contention grants m0.
- Memory-mapped inport address (0xFFF8): a read returns the port register value through m*_rdata with the same one-cycle latency.
